// File: rtl/btb_set_assoc.sv
// btb_set_assoc: set-associative branch target buffer for the fetch unit.
// Each entry stores {valid, tag, content}. Sets use round-robin replacement.
// A sweep engine clears every set after reset and on flush.
// Lookup is pipelined: the set is read at the request edge and the tag
// compare is registered on the following edge.
// Ports:
//   clk, rstN                    clock, synchronous active-low reset
//   lookupValid, lookupPC        fetch-side lookup request
//   hit, predictedPC             registered lookup result (0 on miss)
//   updateValid, updatePC,
//   updateTarget                 resolved taken-branch write port
//   flushReq                     invalidate all entries
//   busy                         invalidation sweep in progress
module btb_set_assoc #(
  parameter int unsigned SET_NUM       = 256,
  parameter int unsigned WAY_NUM       = 2,
  parameter int unsigned TAG_WIDTH     = 8,
  parameter int unsigned CONTENT_WIDTH = 13,
  parameter int unsigned PC_WIDTH      = 32
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                lookupValid,
  input  logic [PC_WIDTH-1:0] lookupPC,
  output logic                hit,
  output logic [PC_WIDTH-1:0] predictedPC,
  input  logic                updateValid,
  input  logic [PC_WIDTH-1:0] updatePC,
  input  logic [PC_WIDTH-1:0] updateTarget,
  input  logic                flushReq,
  output logic                busy
);

  localparam int unsigned IDX_W = $clog2(SET_NUM);
  localparam int unsigned PTR_W = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
  localparam logic [PC_WIDTH-1:0] LO_MASK =
    PC_WIDTH'((64'(1) << (CONTENT_WIDTH + 2)) - 64'(1));

  localparam logic [0:0] ST_SWEEP = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // Parameter legality checks.
  if ((SET_NUM < 2) || ((SET_NUM & (SET_NUM - 1)) != 0)) begin : g_chk_set
    $error("btb_set_assoc: SET_NUM must be a power of two >= 2");
  end
  if (WAY_NUM < 1) begin : g_chk_way
    $error("btb_set_assoc: WAY_NUM must be >= 1");
  end
  if ((IDX_W + TAG_WIDTH + 2 > PC_WIDTH) || (CONTENT_WIDTH + 2 > PC_WIDTH)) begin : g_chk_pc
    $error("btb_set_assoc: index/tag/content fields exceed PC_WIDTH");
  end

  // Storage arrays; only valid bits and pointers are ever cleared.
  logic [WAY_NUM-1:0]       valid_q [SET_NUM];
  logic [PTR_W-1:0]         ptr_q   [SET_NUM];
  logic [TAG_WIDTH-1:0]     tag_q   [SET_NUM][WAY_NUM];
  logic [CONTENT_WIDTH-1:0] cont_q  [SET_NUM][WAY_NUM];

  // Address field extraction.
  logic [IDX_W-1:0]         lk_idx, up_idx;
  logic [TAG_WIDTH-1:0]     lk_tag, up_tag;
  logic [CONTENT_WIDTH-1:0] up_content;
  logic                     unused_ok;

  assign lk_idx     = lookupPC[IDX_W+1:2];
  assign lk_tag     = lookupPC[IDX_W+TAG_WIDTH+1:IDX_W+2];
  assign up_idx     = updatePC[IDX_W+1:2];
  assign up_tag     = updatePC[IDX_W+TAG_WIDTH+1:IDX_W+2];
  assign up_content = updateTarget[CONTENT_WIDTH+1:2];
  assign unused_ok  = ^{lookupPC, updatePC, updateTarget};

  // Control and output registers.
  logic [0:0]          state_q, state_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic                sweep_clr;
  logic                hit_q, hit_d, busy_q, req_q;
  logic [PC_WIDTH-1:0] pred_q, pred_d;

  // Lookup stage-1 registers (set read at the request edge).
  logic [PC_WIDTH-1:0]      lk_pc_q;
  logic [TAG_WIDTH-1:0]     lk_tag_q;
  logic [WAY_NUM-1:0]       rd_valid_q;
  logic [TAG_WIDTH-1:0]     rd_tag_q  [WAY_NUM];
  logic [CONTENT_WIDTH-1:0] rd_cont_q [WAY_NUM];

  assign hit         = hit_q;
  assign predictedPC = pred_q;
  assign busy        = busy_q;

  // Sweep FSM next state; a flush mid-sweep restarts from set 0.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sweep_clr = 1'b0;
    case (state_q)
      ST_SWEEP: begin
        if (flushReq) begin
          cnt_d = '0;
        end else begin
          sweep_clr = rstN;
          cnt_d     = cnt_q + IDX_W'(1);
          if (cnt_q == IDX_W'(SET_NUM - 1)) state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (flushReq) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_SWEEP;
        cnt_d   = '0;
      end
    endcase
  end

  // Stage-2 compare; descending scan so the lowest matching way wins.
  always_comb begin
    hit_d  = 1'b0;
    pred_d = '0;
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      if (req_q && (state_q == ST_READY) && rd_valid_q[w] && (rd_tag_q[w] == lk_tag_q)) begin
        hit_d  = 1'b1;
        pred_d = (lk_pc_q & ~LO_MASK) | PC_WIDTH'({rd_cont_q[w], 2'b00});
      end
    end
  end

  // Update way selection: tag match, else lowest invalid, else round-robin.
  logic [PTR_W-1:0] up_way, match_way, inv_way, ptr_nxt;
  logic             match_found, inv_found, ptr_adv, up_we;

  always_comb begin
    match_found = 1'b0;
    match_way   = '0;
    inv_found   = 1'b0;
    inv_way     = '0;
    up_way      = '0;
    ptr_adv     = 1'b0;
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      if (valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag)) begin
        match_found = 1'b1;
        match_way   = PTR_W'(w);
      end
      if (!valid_q[up_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = PTR_W'(w);
      end
    end
    if (match_found) begin
      up_way = match_way;
    end else if (inv_found) begin
      up_way = inv_way;
    end else begin
      up_way  = ptr_q[up_idx];
      ptr_adv = 1'b1;
    end
  end

  assign ptr_nxt = (ptr_q[up_idx] == PTR_W'(WAY_NUM - 1)) ? '0 : ptr_q[up_idx] + PTR_W'(1);
  assign up_we   = rstN && updateValid && (state_q == ST_READY) && !flushReq;

  // Control state, pipeline valid and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= ST_SWEEP;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      req_q   <= 1'b0;
      hit_q   <= 1'b0;
      pred_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == ST_SWEEP);
      req_q   <= lookupValid && (state_q == ST_READY) && !flushReq;
      hit_q   <= hit_d;
      pred_q  <= pred_d;
    end
  end

  // Valid bits and replacement pointers.
  always_ff @(posedge clk) begin
    if (sweep_clr) begin
      valid_q[cnt_q] <= '0;
      ptr_q[cnt_q]   <= '0;
    end else if (up_we) begin
      valid_q[up_idx][up_way] <= 1'b1;
      if (ptr_adv) ptr_q[up_idx] <= ptr_nxt;
    end
  end

  // Tag/content arrays (RAM-mappable, no reset).
  always_ff @(posedge clk) begin
    if (up_we) begin
      tag_q[up_idx][up_way]  <= up_tag;
      cont_q[up_idx][up_way] <= up_content;
    end
  end

  // Stage-1 read; sees the pre-update contents on a same-cycle write.
  always_ff @(posedge clk) begin
    lk_pc_q    <= lookupPC;
    lk_tag_q   <= lk_tag;
    rd_valid_q <= valid_q[lk_idx];
    for (int w = 0; w < WAY_NUM; w++) begin
      rd_tag_q[w]  <= tag_q[lk_idx][w];
      rd_cont_q[w] <= cont_q[lk_idx][w];
    end
  end

endmodule

// File: tb/tb_btb_set_assoc.sv
// tb_btb_set_assoc: directed self-checking bench for btb_set_assoc
// (SET_NUM=256, WAY_NUM=2, TAG_WIDTH=8, CONTENT_WIDTH=13, PC_WIDTH=32).
module tb_btb_set_assoc;

  logic        clk = 1'b0;
  logic        rstN;
  logic        lookupValid;
  logic [31:0] lookupPC;
  logic        hit;
  logic [31:0] predictedPC;
  logic        updateValid;
  logic [31:0] updatePC;
  logic [31:0] updateTarget;
  logic        flushReq;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  btb_set_assoc #(
    .SET_NUM(256), .WAY_NUM(2), .TAG_WIDTH(8), .CONTENT_WIDTH(13), .PC_WIDTH(32)
  ) dut (
    .clk(clk), .rstN(rstN),
    .lookupValid(lookupValid), .lookupPC(lookupPC),
    .hit(hit), .predictedPC(predictedPC),
    .updateValid(updateValid), .updatePC(updatePC), .updateTarget(updateTarget),
    .flushReq(flushReq), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Drive one cycle of inputs (sampled at the next posedge), then idle.
  task automatic step(input logic lv, input logic [31:0] lpc, input logic uv,
                      input logic [31:0] upc, input logic [31:0] utg, input logic fl);
    @(negedge clk);
    lookupValid = lv; lookupPC = lpc;
    updateValid = uv; updatePC = upc; updateTarget = utg;
    flushReq = fl;
    @(negedge clk);
    lookupValid = 1'b0; updateValid = 1'b0; flushReq = 1'b0;
  endtask

  task automatic update(input logic [31:0] pc, input logic [31:0] tgt);
    step(1'b0, 32'h0, 1'b1, pc, tgt, 1'b0);
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic exp_hit, input logic [31:0] exp_pc);
    step(1'b1, pc, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    check({tag, ".hit"}, 32'(hit), 32'(exp_hit));
    check({tag, ".pc"}, predictedPC, exp_pc);
  endtask

  // Count edges from now until busy drops; bounded.
  task automatic wait_sweep(output int edges, output int hits);
    edges = 0; hits = 0;
    do begin
      @(posedge clk); #1;
      edges++;
      if (hit) hits++;
    end while (busy && edges < 400);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, hits, busy_cnt;
    rstN = 1'b0; lookupValid = 1'b0; lookupPC = 32'h0;
    updateValid = 1'b0; updatePC = 32'h0; updateTarget = 32'h0; flushReq = 1'b0;

    // Reset and initial sweep, with lookups throughout the window.
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 32'd1);
    check("rst.hit", 32'(hit), 32'd0);
    check("rst.pc", predictedPC, 32'h0);
    @(negedge clk);
    rstN = 1'b1; lookupValid = 1'b1; lookupPC = 32'h0000_1004;
    wait_sweep(edges, hits);
    @(negedge clk);
    lookupValid = 1'b0;
    check("rst.busy_len", 32'(edges), 32'd256);
    check("rst.sweep_hits", 32'(hits), 32'd0);
    check("rst.busy_low", 32'(busy), 32'd0);

    // Basic hit, different tag, idle lookup.
    update(32'h0000_1004, 32'h0000_1F00);
    lookup("basic", 32'h0000_1004, 1'b1, 32'h0000_1F00);
    lookup("diff_tag", 32'h0000_5004, 1'b0, 32'h0);
    step(1'b0, 32'h0000_1004, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    check("idle.hit", 32'(hit), 32'd0);
    check("idle.pc", predictedPC, 32'h0);

    // Eviction in set 1 (way0 held 0x1004, ptr 0).
    update(32'h0000_0404, 32'h0000_0100);
    update(32'h0000_0804, 32'h0000_0200);
    update(32'h0000_0C04, 32'h0000_0300);
    lookup("evict.0404", 32'h0000_0404, 1'b0, 32'h0);
    lookup("evict.0804", 32'h0000_0804, 1'b1, 32'h0000_0200);
    lookup("evict.0C04", 32'h0000_0C04, 1'b1, 32'h0000_0300);
    lookup("evict.1004", 32'h0000_1004, 1'b0, 32'h0);

    // Tag refresh keeps the pointer; next victim is still way 0.
    update(32'h0000_0804, 32'h0000_2000);
    lookup("refresh.0804", 32'h0000_0804, 1'b1, 32'h0000_2000);
    update(32'h0000_1404, 32'h0000_0500);
    lookup("fourth.0804", 32'h0000_0804, 1'b0, 32'h0);
    lookup("fourth.0C04", 32'h0000_0C04, 1'b1, 32'h0000_0300);
    lookup("fourth.1404", 32'h0000_1404, 1'b1, 32'h0000_0500);

    // Upper target bits come from the lookup PC.
    update(32'h1234_0008, 32'h0000_7FFC);
    lookup("upper.a", 32'h1234_0008, 1'b1, 32'h1234_7FFC);
    lookup("upper.b", 32'h0234_0008, 1'b1, 32'h0234_7FFC);

    // Same-cycle update and lookup: read-before-write.
    step(1'b1, 32'h0000_0104, 1'b1, 32'h0000_0104, 32'h0000_0400, 1'b0);
    @(posedge clk); #1;
    check("rbw.hit", 32'(hit), 32'd0);
    lookup("rbw.after", 32'h0000_0104, 1'b1, 32'h0000_0400);

    // Update at edge N visible to a lookup at edge N+1.
    @(negedge clk);
    updateValid = 1'b1; updatePC = 32'h0000_0204; updateTarget = 32'h0000_0600;
    @(negedge clk);
    updateValid = 1'b0; lookupValid = 1'b1; lookupPC = 32'h0000_0204;
    @(negedge clk);
    lookupValid = 1'b0;
    @(posedge clk); #1;
    check("b2b.hit", 32'(hit), 32'd1);
    check("b2b.pc", predictedPC, 32'h0000_0600);

    // Flush, restarted 100 cycles later; lookups and updates every cycle.
    busy_cnt = 0; hits = 0; edges = 0;
    do begin
      @(negedge clk);
      flushReq = (edges == 0) || (edges == 100);
      lookupValid = 1'b1; lookupPC = 32'h0000_0C04;
      updateValid = 1'b1; updatePC = 32'h0000_3008; updateTarget = 32'h0000_0700;
      @(posedge clk); #1;
      edges++;
      if (busy) busy_cnt++;
      if (hit) hits++;
    end while (busy && edges < 600);
    @(negedge clk);
    flushReq = 1'b0; lookupValid = 1'b0; updateValid = 1'b0;
    check("flush.busy_len", 32'(busy_cnt), 32'd356);
    check("flush.hits", 32'(hits), 32'd0);
    lookup("flush.0C04", 32'h0000_0C04, 1'b0, 32'h0);
    lookup("flush.3008", 32'h0000_3008, 1'b0, 32'h0);
    lookup("flush.1234", 32'h1234_0008, 1'b0, 32'h0);
    check("flush.busy_low", 32'(busy), 32'd0);

    // Reset asserted while a hit is on the outputs.
    update(32'h0000_0404, 32'h0000_0100);
    step(1'b1, 32'h0000_0404, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    check("midrst.pre_hit", 32'(hit), 32'd1);
    @(negedge clk);
    rstN = 1'b0;
    @(posedge clk); #1;
    check("midrst.hit", 32'(hit), 32'd0);
    check("midrst.pc", predictedPC, 32'h0);
    check("midrst.busy", 32'(busy), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    wait_sweep(edges, hits);
    check("midrst.busy_len", 32'(edges), 32'd256);
    lookup("midrst.0404", 32'h0000_0404, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/btb_set_assoc.md
# btb_set_assoc

Parametrised, set-associative branch target buffer for the fetch unit. It replaces the fixed 1024-entry direct-mapped tag/content layout with configurable set count, way count, tag width and stored-target width. It adds valid bits, per-set round-robin replacement, a 1-cycle registered lookup and a sweep-based invalidation engine used after reset and on flush. It sits beside the PC register: fetch presents the PC each cycle, and the branch-resolution stage writes resolved taken branches back.

## Interface
- `SET_NUM`, 256: number of sets; power of two, ≥ 2. `IDX_W = $clog2(SET_NUM)`.
- `WAY_NUM`, 2: ways per set; ≥ 1.
- `TAG_WIDTH`, 8: tag bits stored per entry.
- `CONTENT_WIDTH`, 13: low target-PC bits stored, excluding the 2 alignment bits.
- `PC_WIDTH`, 32: PC width. Elaboration error unless `IDX_W+TAG_WIDTH+2 ≤ PC_WIDTH` and `CONTENT_WIDTH+2 ≤ PC_WIDTH`.

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rstN` in 1: synchronous, active-low reset.
- `lookupValid` in 1: lookup request this cycle.
- `lookupPC` in PC_WIDTH: PC being fetched.
- `hit` out 1: registered; the lookup issued last cycle hit.
- `predictedPC` out PC_WIDTH: registered predicted target; 0 when `hit`=0.
- `updateValid` in 1: write a resolved taken branch.
- `updatePC` in PC_WIDTH: branch PC.
- `updateTarget` in PC_WIDTH: branch target.
- `flushReq` in 1: invalidate all entries.
- `busy` out 1: invalidation sweep in progress.

## Operation
- Address split, for any PC p: index = p[IDX_W+1:2]; tag = p[IDX_W+TAG_WIDTH+1:IDX_W+2]; content = p[CONTENT_WIDTH+1:2].
- Each entry holds {valid, tag, content}. Each set holds a round-robin pointer of `$clog2(WAY_NUM)` bits, or no bits when WAY_NUM=1.
- Target reconstruction: predictedPC = {lookupPC[PC_WIDTH-1:CONTENT_WIDTH+2], content, 2'b00}. The upper bits come from the registered lookup PC.
- Lookup hit: some way in the indexed set has valid=1 and a matching tag. Ways are compared in parallel. If more than one way matches, the lowest-numbered way wins.
- Update way selection, in priority order:
  - a valid way with a matching tag is overwritten, and the pointer is unchanged;
  - otherwise the lowest-numbered invalid way is used, and the pointer is unchanged;
  - otherwise the way at the pointer is used, and the pointer increments mod WAY_NUM.
- The written entry is {1, tag(updatePC), content(updateTarget)}.
- Lookup and update in the same cycle to the same set: the lookup observes the pre-update state (read-before-write).
- FSM states: `SWEEP` and `READY`.
  - Reset enters `SWEEP` with sweep counter = 0.
  - In `SWEEP`, each cycle clears the valid bits and pointer of set[counter] and increments the counter. After set SET_NUM-1 is cleared, the FSM moves to `READY`.
  - `flushReq` in `READY` enters `SWEEP` with counter = 0.
  - `flushReq` during `SWEEP` restarts the counter at 0.
  - While in `SWEEP`, updates are dropped and lookups return `hit`=0.
- Storage contents other than valid bits and pointers are not reset, so the arrays map onto synchronous RAM.

## Timing
- Reset values: `hit`=0, `predictedPC`=0, `busy`=1 while `rstN`=0 and throughout the sweep.
- `busy` is high for exactly SET_NUM cycles after reset release or after an accepted `flushReq`. A restart mid-sweep extends this to SET_NUM cycles counted from the restart.
- Lookup latency is 1 cycle. A request at edge N produces `hit`/`predictedPC` valid after edge N+1.
- When `lookupValid`=0, the next-cycle `hit` is 0.
- An update accepted at edge N is visible to a lookup issued at edge N+1.
- A `flushReq` accepted at edge N forces the lookup result registered at edge N+1 to miss.
- Reset asserted mid-operation: all outputs return to their reset values on the next edge, and the sweep restarts when reset is released.

## Test plan
Configuration for all scenarios: SET_NUM=256, WAY_NUM=2, TAG_WIDTH=8, CONTENT_WIDTH=13.
- Reset: hold `rstN`=0 for 3 cycles, then release → `busy`=1 for 256 cycles and then 0. Lookups of 0x0000_1004 issued during this window return `hit`=0.
- Basic hit: update PC 0x0000_1004 with target 0x0000_1F00, then look up 0x0000_1004 → next cycle `hit`=1, `predictedPC`=0x0000_1F00. A lookup of 0x0000_5004 (same index, different tag) → `hit`=0.
- Eviction: update 0x0404, 0x0804, 0x0C04 (all set 1, tags 1/2/3) → 0x0404 misses; 0x0804 and 0x0C04 hit. A fourth PC, 0x1404, then evicts 0x0804.
- Tag refresh: update 0x0804 with a new target 0x0000_2000 → lookup returns 0x0000_2000, and the round-robin victim order is unchanged.
- Same-cycle conflict: update 0x0104 and look up 0x0104 in the same cycle → `hit`=0. The same lookup one cycle later → `hit`=1.
- Flush: with entries populated, assert `flushReq`, then assert it again 100 cycles later → `busy` is held for 356 total cycles, all lookups miss, and updates presented during the sweep do not persist.
